// File: rtl/matriz_stream_io.sv
// Stream wrapper for the 5x5 int8 matrix multiplier: collects A and B row-major,
// holds them on packed buses for one multiplier pass, then streams the product out.
`timescale 1ns/1ps
module matriz_stream_io #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        abort,
    input  logic [ELEM_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DIM*DIM*ELEM_W-1:0]   matriz_a,
    output logic [DIM*DIM*ELEM_W-1:0]   matriz_b,
    output logic                        mult_start,
    input  logic [DIM*DIM*ELEM_W-1:0]   matriz_c,
    input  logic                        mult_done,
    output logic [ELEM_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        error
);
    localparam int N  = DIM * DIM;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(DIM);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RUN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t            state_reg;
    logic [IW-1:0]     count_reg;
    logic [IW-1:0]     idx_reg;
    logic [RW-1:0]     run_cnt_reg;
    logic              in_ready_reg;
    logic              mult_start_reg;
    logic              out_valid_reg;
    logic              error_reg;
    logic [ELEM_W-1:0] a_reg [N];
    logic [ELEM_W-1:0] b_reg [N];
    logic [ELEM_W-1:0] c_reg [N];
    logic [ELEM_W-1:0] c_in  [N];

    logic accept;
    logic xfer;

    assign accept = in_valid & in_ready_reg;
    assign xfer   = out_valid_reg & out_ready;

    // Element (r,c) sits at r*DIM*ELEM_W + c*ELEM_W, i.e. flat index k = r*DIM + c.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign matriz_a[gi*ELEM_W +: ELEM_W] = a_reg[gi];
            assign matriz_b[gi*ELEM_W +: ELEM_W] = b_reg[gi];
            assign c_in[gi]                      = matriz_c[gi*ELEM_W +: ELEM_W];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            idx_reg        <= '0;
            run_cnt_reg    <= '0;
            in_ready_reg   <= 1'b0;
            mult_start_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            error_reg      <= 1'b0;
            a_reg          <= '{default: '0};
            b_reg          <= '{default: '0};
            c_reg          <= '{default: '0};
        end else if (abort) begin
            // Operands and the sticky error survive an abort.
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            idx_reg        <= '0;
            run_cnt_reg    <= '0;
            in_ready_reg   <= 1'b1;
            mult_start_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        a_reg[0]  <= in_data;
                        count_reg <= IW'(1);
                        state_reg <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (accept) begin
                        a_reg[count_reg] <= in_data;
                        if (count_reg == LAST_IDX) begin
                            count_reg <= '0;
                            state_reg <= S_LOAD_B;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (accept) begin
                        b_reg[count_reg] <= in_data;
                        if (count_reg == LAST_IDX) begin
                            count_reg      <= '0;
                            run_cnt_reg    <= '0;
                            in_ready_reg   <= 1'b0;
                            mult_start_reg <= 1'b1;
                            state_reg      <= S_RUN;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (run_cnt_reg == LAST_ROW) begin
                        run_cnt_reg    <= '0;
                        mult_start_reg <= 1'b0;
                        state_reg      <= S_CAPTURE;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // A missing done is flagged but the product is still taken.
                    c_reg         <= c_in;
                    error_reg     <= error_reg | ~mult_done;
                    idx_reg       <= '0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= S_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign mult_start = mult_start_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = c_reg[idx_reg];
    assign out_last   = out_valid_reg && (idx_reg == LAST_IDX);
    assign busy       = (state_reg != S_IDLE);
    assign error      = error_reg;

endmodule
